// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: control-transfer ops
// and sequencer states.
package pc_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JZ   = 4'd2;
    localparam logic [3:0] OP_JNZ  = 4'd3;
    localparam logic [3:0] OP_CALL = 4'd4;
    localparam logic [3:0] OP_RET  = 4'd5;
    localparam logic [3:0] OP_RETI = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;
    localparam logic [3:0] OP_EI   = 4'd8;
    localparam logic [3:0] OP_DI   = 4'd9;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// Return-address LIFO: push writes entry[count], pop exposes entry[count-1].
// Entries are not reset; only the occupancy count is.
module pc_seq_ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_count;
    logic [SPW-1:0]   w_count_dec;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full        = (r_count == SPW'(DEPTH));
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign w_count_dec = r_count - SPW'(1);
    assign w_wr_idx    = r_count[AW-1:0];
    assign w_rd_idx    = w_count_dec[AW-1:0];
    assign top_data    = r_mem[w_rd_idx];
    assign w_do_push   = push && !full && !rst;
    assign w_do_pop    = pop && !empty && !push;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + SPW'(1);
        end else if (w_do_pop) begin
            r_count <= w_count_dec;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Next-address sequencer for the 8-bit program counter: op decode, return
// stack for CALL/RET, one vectored interrupt, HALT/FAULT state machine.
//
// state     | meaning
// ST_RUN    | executing; ops decoded normally
// ST_HALTED | pc held at pc_in; only an interrupt take or rst leaves
// ST_FAULT  | stack over/underflow; pc held, op and irq ignored until rst
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] IRQ_VEC = 8'hF0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       pc_in,
    input  logic [3:0]             op,
    input  logic [WIDTH-1:0]       target,
    input  logic                   zero,
    input  logic                   irq,
    output logic                   pc_ld,
    output logic [WIDTH-1:0]       pc_addr,
    output logic                   irq_ack,
    output logic                   halted,
    output logic                   fault,
    output logic                   ie,
    output logic [$clog2(DEPTH):0] sp
);
    logic [1:0]       r_state;
    logic             r_ie;
    logic             r_halted;
    logic             r_fault;

    logic [1:0]       w_state_nxt;
    logic             w_ie_nxt;
    logic             w_take;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_data;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_full;
    logic             w_empty;

    pc_seq_ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .top_data  (w_top),
        .full      (w_full),
        .empty     (w_empty),
        .count     (sp)
    );

    assign w_pc_inc = pc_in + WIDTH'(1);
    // A full stack defers the interrupt rather than faulting.
    assign w_take   = irq && r_ie && (r_state != ST_FAULT) && !w_full && !rst;

    always_comb begin
        pc_ld       = 1'b0;
        pc_addr     = '0;
        irq_ack     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = '0;
        w_state_nxt = r_state;
        w_ie_nxt    = r_ie;
        if (rst) begin
            w_state_nxt = ST_RUN;
            w_ie_nxt    = 1'b0;
        end else if (w_take) begin
            w_push      = 1'b1;
            w_push_data = (r_state == ST_HALTED) ? w_pc_inc : pc_in;
            pc_ld       = 1'b1;
            pc_addr     = IRQ_VEC;
            irq_ack     = 1'b1;
            w_ie_nxt    = 1'b0;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN) begin
            case (op)
                OP_JMP: begin
                    pc_ld   = 1'b1;
                    pc_addr = target;
                end
                OP_JZ: if (zero) begin
                    pc_ld   = 1'b1;
                    pc_addr = target;
                end
                OP_JNZ: if (!zero) begin
                    pc_ld   = 1'b1;
                    pc_addr = target;
                end
                OP_CALL: begin
                    pc_ld = 1'b1;
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_push_data = w_pc_inc;
                        pc_addr     = target;
                    end else begin
                        pc_addr     = pc_in;
                        w_state_nxt = ST_FAULT;
                    end
                end
                OP_RET, OP_RETI: begin
                    pc_ld = 1'b1;
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        pc_addr = w_top;
                        if (op == OP_RETI) begin
                            w_ie_nxt = 1'b1;
                        end
                    end else begin
                        pc_addr     = pc_in;
                        w_state_nxt = ST_FAULT;
                    end
                end
                OP_HALT: begin
                    pc_ld       = 1'b1;
                    pc_addr     = pc_in;
                    w_state_nxt = ST_HALTED;
                end
                OP_EI:   w_ie_nxt = 1'b1;
                OP_DI:   w_ie_nxt = 1'b0;
                default: ;
            endcase
        end else begin
            // HALTED and FAULT both hold the counter; unknown encodings fault.
            pc_ld   = 1'b1;
            pc_addr = pc_in;
            if (r_state != ST_HALTED) begin
                w_state_nxt = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_ie     <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ie     <= w_ie_nxt;
            r_halted <= (w_state_nxt == ST_HALTED);
            r_fault  <= (w_state_nxt == ST_FAULT);
        end
    end

    assign halted = r_halted;
    assign fault  = r_fault;
    assign ie     = r_ie;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: inputs change on the falling edge, every check
// is taken 1ns later so combinational and registered outputs are both stable.
module tb_pc_seq;
    import pc_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_in;
    logic [3:0] op;
    logic [7:0] target;
    logic       zero;
    logic       irq;
    logic       pc_ld;
    logic [7:0] pc_addr;
    logic       irq_ack;
    logic       halted;
    logic       fault;
    logic       ie;
    logic [2:0] sp;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_seq #(.WIDTH(8), .DEPTH(4), .IRQ_VEC(8'hF0)) dut (
        .clk     (clk),
        .rst     (rst),
        .pc_in   (pc_in),
        .op      (op),
        .target  (target),
        .zero    (zero),
        .irq     (irq),
        .pc_ld   (pc_ld),
        .pc_addr (pc_addr),
        .irq_ack (irq_ack),
        .halted  (halted),
        .fault   (fault),
        .ie      (ie),
        .sp      (sp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [3:0] o, input logic [7:0] p,
                       input logic [7:0] t, input logic z, input logic q);
        @(negedge clk);
        rst = r; op = o; pc_in = p; target = t; zero = z; irq = q;
        #1;
    endtask

    task automatic chk_ld(input string tag, input logic ld, input logic [7:0] addr);
        chk({tag, ".ld"}, 32'(pc_ld), 32'(ld));
        chk({tag, ".addr"}, 32'(pc_addr), 32'(addr));
    endtask

    initial begin
        rst = 1'b1; op = OP_NOP; pc_in = '0; target = '0; zero = 1'b0; irq = 1'b0;

        // reset holds outputs quiet even with a JMP on the bus
        drv(1, OP_JMP, 8'h00, 8'h55, 0, 1);
        drv(1, OP_JMP, 8'h00, 8'h55, 0, 1);
        chk_ld("rst_jmp", 0, 8'h00);
        chk("rst_ack", 32'(irq_ack), 0);

        drv(0, OP_NOP, 8'h05, 8'h00, 0, 0);
        chk_ld("nop", 0, 8'h00);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_ie", 32'(ie), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);

        drv(0, OP_JZ, 8'h06, 8'h20, 1, 0);  chk_ld("jz_taken", 1, 8'h20);
        drv(0, OP_JZ, 8'h06, 8'h20, 0, 0);  chk_ld("jz_fall", 0, 8'h00);
        drv(0, OP_JNZ, 8'h07, 8'h20, 0, 0); chk_ld("jnz_taken", 1, 8'h20);
        drv(0, OP_JNZ, 8'h07, 8'h20, 1, 0); chk_ld("jnz_fall", 0, 8'h00);
        drv(0, OP_JMP, 8'h08, 8'h77, 0, 0); chk_ld("jmp", 1, 8'h77);

        drv(0, OP_CALL, 8'h10, 8'h40, 0, 0); chk_ld("call", 1, 8'h40);
        drv(0, OP_NOP, 8'h40, 8'h00, 0, 0);  chk("call_sp", 32'(sp), 1);
        drv(0, OP_RET, 8'h41, 8'h00, 0, 0);  chk_ld("ret", 1, 8'h11);
        drv(0, OP_NOP, 8'h11, 8'h00, 0, 0);  chk("ret_sp", 32'(sp), 0);
        drv(0, OP_CALL, 8'hFF, 8'h50, 0, 0); chk_ld("call_ff", 1, 8'h50);
        drv(0, OP_RET, 8'h50, 8'h00, 0, 0);  chk_ld("ret_wrap", 1, 8'h00);

        // interrupt from RUN, then RETI
        drv(0, OP_EI, 8'h2A, 8'h00, 0, 0);
        drv(0, OP_JMP, 8'h30, 8'h99, 0, 1);
        chk("irq_ie_before", 32'(ie), 1);
        chk("irq_ack", 32'(irq_ack), 1);
        chk_ld("irq", 1, 8'hF0);
        drv(0, OP_NOP, 8'hF0, 8'h00, 0, 1);
        chk("irq_ie_after", 32'(ie), 0);
        chk("irq_sp", 32'(sp), 1);
        chk("irq_masked_ack", 32'(irq_ack), 0);
        chk_ld("irq_masked", 0, 8'h00);
        drv(0, OP_RETI, 8'hF5, 8'h00, 0, 0); chk_ld("reti", 1, 8'h30);
        drv(0, OP_NOP, 8'h30, 8'h00, 0, 0);
        chk("reti_ie", 32'(ie), 1);
        chk("reti_sp", 32'(sp), 0);
        drv(0, OP_DI, 8'h31, 8'h00, 0, 0);
        drv(0, OP_NOP, 8'h32, 8'h00, 0, 0);  chk("di_ie", 32'(ie), 0);

        // HALT, wake by interrupt
        drv(0, OP_EI, 8'h21, 8'h00, 0, 0);
        drv(0, OP_HALT, 8'h22, 8'h00, 0, 0); chk_ld("halt", 1, 8'h22);
        for (int i = 0; i < 3; i++) begin
            drv(0, OP_JMP, 8'h22, 8'h99, 0, 0);
            chk("halt_flag", 32'(halted), 1);
            chk_ld("halt_hold", 1, 8'h22);
        end
        drv(0, OP_NOP, 8'h22, 8'h00, 0, 1);
        chk("halt_irq_ack", 32'(irq_ack), 1);
        chk_ld("halt_irq", 1, 8'hF0);
        drv(0, OP_NOP, 8'hF0, 8'h00, 0, 0);
        chk("wake_halted", 32'(halted), 0);
        chk("wake_sp", 32'(sp), 1);
        drv(0, OP_RETI, 8'hF1, 8'h00, 0, 0); chk_ld("wake_reti", 1, 8'h23);

        // full stack defers the interrupt while halted
        for (int i = 0; i < 4; i++) begin
            drv(0, OP_CALL, 8'(8'h60 + i), 8'(8'h61 + i), 0, 0);
        end
        drv(0, OP_HALT, 8'h70, 8'h00, 0, 0);
        chk("full_sp", 32'(sp), 4);
        drv(0, OP_NOP, 8'h70, 8'h00, 0, 1);
        chk("defer_ack", 32'(irq_ack), 0);
        chk_ld("defer", 1, 8'h70);
        drv(0, OP_NOP, 8'h70, 8'h00, 0, 1);
        chk("defer_halted", 32'(halted), 1);
        chk("defer_sp", 32'(sp), 4);

        // overflow fault on fifth CALL
        drv(1, OP_NOP, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv(0, OP_CALL, 8'(8'h80 + i), 8'(8'h81 + i), 0, 0);
        end
        drv(0, OP_CALL, 8'h84, 8'h90, 0, 0); chk_ld("ovf", 1, 8'h84);
        drv(0, OP_EI, 8'h84, 8'h90, 0, 0);
        chk("ovf_fault", 32'(fault), 1);
        chk("ovf_sp", 32'(sp), 4);
        chk_ld("ovf_hold", 1, 8'h84);
        drv(0, OP_JMP, 8'h84, 8'h90, 0, 0);
        chk("ovf_fault2", 32'(fault), 1);
        chk("ovf_ie_ignored", 32'(ie), 0);
        drv(1, OP_NOP, 8'h00, 8'h00, 0, 0);
        drv(0, OP_NOP, 8'h00, 8'h00, 0, 0);
        chk("ovf_clr", 32'(fault), 0);
        chk("ovf_clr_sp", 32'(sp), 0);

        // underflow fault; irq ignored in FAULT; reset mid-CALL
        drv(0, OP_EI, 8'h11, 8'h00, 0, 0);
        drv(0, OP_RET, 8'h12, 8'h00, 0, 0);  chk_ld("unf", 1, 8'h12);
        drv(0, OP_NOP, 8'h12, 8'h00, 0, 1);
        chk("unf_fault", 32'(fault), 1);
        chk("unf_irq_ack", 32'(irq_ack), 0);
        chk_ld("unf_hold", 1, 8'h12);
        drv(1, OP_CALL, 8'h12, 8'h40, 0, 1);
        chk_ld("rst_call", 0, 8'h00);
        chk("rst_call_ack", 32'(irq_ack), 0);
        drv(0, OP_NOP, 8'h00, 8'h00, 0, 0);
        chk("rst_call_sp", 32'(sp), 0);
        chk("rst_call_fault", 32'(fault), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Next-address sequencer for the 8-bit program counter in the one-cycle CPU. Each cycle it decodes the control-transfer op of the current instruction and drives the counter's load strobe and load address. It owns a return-address stack for CALL/RET, a single vectored interrupt with enable flag, and a HALT/FAULT state machine. The counter increments on its own when pc_ld=0, so every hold or redirect is a load.

Parameters:
WIDTH, 8, address width; must match the program counter
DEPTH, 4, return-stack entries (power of 2, 2..16)
IRQ_VEC, 8'hF0, interrupt vector address (WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset; same net as the program counter reset
pc_in  in  WIDTH  current counter value (address of executing instruction)
op  in  4  decoded control op: 0 NOP, 1 JMP, 2 JZ, 3 JNZ, 4 CALL, 5 RET, 6 RETI, 7 HALT, 8 EI, 9 DI, 10-15 NOP
target  in  WIDTH  jump/call destination from instruction
zero  in  1  ALU zero flag, valid same cycle
irq  in  1  level interrupt request
pc_ld  out  1  load strobe to counter (combinational)
pc_addr  out  WIDTH  load address to counter (combinational; 0 when pc_ld=0)
irq_ack  out  1  interrupt taken this cycle; core must suppress the current instruction's writeback (combinational)
halted  out  1  registered; state==HALTED
fault  out  1  registered; state==FAULT
ie  out  1  registered interrupt enable
sp  out  clog2(DEPTH)+1  registered stack occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, ie=0, sp=0, halted=0, fault=0. Stack contents are don't-care. While rst=1: pc_ld=0, irq_ack=0.
- States: RUN, HALTED, FAULT. halted and fault are registered decodes of the state.
- Interrupt take condition: irq & ie & (state!=FAULT) & (sp<DEPTH). It has priority over op.
  - The current op is discarded. Push return address: pc_in in RUN, pc_in+1 in HALTED.
  - pc_ld=1, pc_addr=IRQ_VEC, irq_ack=1. Next cycle: ie=0, state=RUN.
  - Stack full: the interrupt is deferred, with no fault.
- RUN, no interrupt:
  - JMP: ld target.
  - JZ: ld target if zero, else pc_ld=0.
  - JNZ: ld target if !zero, else pc_ld=0.
  - CALL: if sp<DEPTH, push pc_in+1 and ld target. If full, go to FAULT with ld pc_in and no push.
  - RET: if sp>0, pop and ld the popped value. If empty, go to FAULT with ld pc_in.
  - RETI: same as RET, plus ie=1 on success.
  - HALT: ld pc_in; state goes to HALTED.
  - EI: ie=1. DI: ie=0. NOP: pc_ld=0.
- HALTED: ld pc_in every cycle and ignore op. Exit only by interrupt take or rst.
- FAULT: ld pc_in every cycle. Ignore op and irq. Exit only by rst.
- Arithmetic: pc_in+1 is modulo 2^WIDTH, so 8'hFF+1 = 8'h00.
- Stack is LIFO: push writes entry[sp] then sp+1; pop reads entry[sp-1] then sp-1. Only one push or pop occurs per cycle.
- Latency: redirects are zero-cycle combinational. The counter shows the new address the cycle after.
- rst asserted mid-CALL, during an interrupt, or in FAULT: reset wins and no push/pop is committed.

Decomposition:
- Shared package: op encodings (OP_NOP..OP_DI), state encoding (ST_RUN, ST_HALTED, ST_FAULT).
- One natural sub-module: ret_stack (DEPTH x WIDTH LIFO with push, pop, full, empty, count).
- pc_seq holds the FSM, ie, and the combinational next-address mux.

Test Plan:
- rst, then NOP at pc_in=8'h05 -> pc_ld=0, sp=0, ie=0, halted=0.
- JZ target=8'h20: zero=1 -> pc_ld=1, pc_addr=8'h20; zero=0 -> pc_ld=0. JNZ gives the inverse.
- CALL target=8'h40 at pc_in=8'h10 -> ld 8'h40, sp=1. Then RET -> ld 8'h11, sp=0. CALL at pc_in=8'hFF pushes 8'h00.
- DEPTH=4: five nested CALLs -> fifth causes fault=1 and pc_ld=1 with pc_addr=pc_in thereafter. Separately, RET with sp=0 -> FAULT. Only rst clears.
- EI; irq=1 at pc_in=8'h30 with op=JMP -> irq_ack=1, ld 8'hF0, push 8'h30, ie=0 next cycle. RETI -> ld 8'h30, ie=1. With ie=0, irq is ignored.
- HALT at pc_in=8'h22 -> halted=1, pc held at 8'h22 for N cycles. EI was done beforehand, then irq -> ld 8'hF0, push 8'h23, halted=0. With sp=DEPTH, irq is deferred and state stays HALTED.
